dmem_arbiter: RTL

Two-port arbiter sharing the single-ported `data_memory` between the CPU load/store unit (port 0) and a debug/DMA loader (port 1). It grants one requester at a time with round-robin fairness and bounded bursts, drives the memory's address, write-data and strobe inputs, and returns registered read data on the granted port's response channel. It sits between the requesters and `data_memory`, whose write happens on the `clk` rising edge and whose `read_data` is valid combinationally from the address.

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester channels plus the data_memory side of the arbiter.
// slave = arbiter view; master = requesters and memory (as driven by a bench or wrapper).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 64
);
  logic              req0_valid, req0_write, req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid, req1_write, req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_Write, mem_Read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_read_data,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_address, mem_write_data, mem_Write, mem_Read
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_read_data,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_address, mem_write_data, mem_Write, mem_Read
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-ported data memory
// between the load/store unit (port 0) and the debug/DMA loader (port 1).
module dmem_arbiter #(
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  localparam logic [7:0] MAX_B  = 8'(MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;   // port favoured on a simultaneous request
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [1:0]        rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0] vld, wr, gnt, acc;
  logic       own, oth;
  logic [1:0] oth_st;

  assign vld = {bus.req1_valid, bus.req0_valid};
  assign wr  = {bus.req1_write, bus.req0_write};
  // Reset masks the grant so nothing is accepted or strobed while it is held.
  assign gnt = rst ? 2'b00 : {state_q == GRANT1, state_q == GRANT0};
  assign acc = gnt & vld;

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;

  always_comb begin
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    if (gnt[0]) begin
      bus.mem_address    = bus.req0_addr;
      bus.mem_write_data = bus.req0_wdata;
    end else if (gnt[1]) begin
      bus.mem_address    = bus.req1_addr;
      bus.mem_write_data = bus.req1_wdata;
    end
    bus.mem_Write = |(acc & wr);
    bus.mem_Read  = |(acc & ~wr);
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 8'd1;
    own     = (state_q == GRANT1);
    oth     = ~own;
    oth_st  = own ? GRANT0 : GRANT1;
    case (state_q)
      IDLE: begin
        if (vld[0] && (!vld[1] || !prio_q)) begin
          state_d = GRANT0;
          cnt_d   = '0;
        end else if (vld[1]) begin
          state_d = GRANT1;
          cnt_d   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (!vld[own]) begin
          prio_d  = oth;
          cnt_d   = '0;
          state_d = vld[oth] ? oth_st : IDLE;
        end else if (cnt_inc == MAX_B) begin
          // Burst exhausted: hand over if the other port waits, else restart the count.
          cnt_d = '0;
          if (vld[oth]) begin
            state_d = oth_st;
            prio_d  = oth;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_vld_d = acc & ~wr;
    rdata0_d  = rsp_vld_d[0] ? bus.mem_read_data : rdata0_q;
    rdata1_d  = rsp_vld_d[1] ? bus.mem_read_data : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      rsp_vld_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end
endmodule
